// File: rtl/timer_multi.sv
// Multi-channel timer on the simple peripheral bus: per channel a prescaler,
// a one-shot/periodic compare counter, a write-1-to-clear pending flag and an interrupt enable.
module timer_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       data_i,
    input  logic [31:0]       addr_i,
    input  logic              we_i,
    output logic [31:0]       data_o,
    output logic [NUM_CH-1:0] int_vec_o,
    output logic              int_sig_o
);
    localparam logic [CNT_W-1:0]   CT_ONE   = CNT_W'(1);
    localparam logic [PRESC_W-1:0] PCNT_ONE = PRESC_W'(1);

    logic [NUM_CH-1:0]  en_q, en_d, ie_q, ie_d, pend_q, pend_d, mode_q, mode_d;
    logic [CNT_W-1:0]   ct_q    [NUM_CH];
    logic [CNT_W-1:0]   ct_d    [NUM_CH];
    logic [CNT_W-1:0]   value_q [NUM_CH];
    logic [CNT_W-1:0]   value_d [NUM_CH];
    logic [PRESC_W-1:0] presc_q [NUM_CH];
    logic [PRESC_W-1:0] presc_d [NUM_CH];
    logic [PRESC_W-1:0] pcnt_q  [NUM_CH];
    logic [PRESC_W-1:0] pcnt_d  [NUM_CH];

    logic [NUM_CH-1:0] ctrlWr, ctWr, valueWr, prescWr, tick, fire;
    logic              chanSpace, statusWr;
    logic [31:0]       rdata;
    logic              unusedBits;

    assign chanSpace  = we_i & ~addr_i[7];
    assign statusWr   = we_i & (addr_i[7:0] == 8'h80);
    assign unusedBits = ^{addr_i[31:8], data_i};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic selCh;
        assign selCh      = chanSpace & (addr_i[6:4] == 3'(g));
        assign ctrlWr[g]  = selCh & (addr_i[3:0] == 4'h0);
        assign ctWr[g]    = selCh & (addr_i[3:0] == 4'h4);
        assign valueWr[g] = selCh & (addr_i[3:0] == 4'h8);
        assign prescWr[g] = selCh & (addr_i[3:0] == 4'hC);
        assign tick[g]    = en_q[g] & (pcnt_q[g] == presc_q[g]);
        assign fire[g]    = tick[g] & (ct_q[g] >= value_q[g]);
    end

    // Hardware update first, then bus writes override it; a hardware PEND set beats any clear.
    always_comb begin
        en_d   = en_q;
        ie_d   = ie_q;
        pend_d = pend_q;
        mode_d = mode_q;
        for (int i = 0; i < NUM_CH; i++) begin
            ct_d[i]    = ct_q[i];
            value_d[i] = value_q[i];
            presc_d[i] = presc_q[i];
            pcnt_d[i]  = pcnt_q[i];

            if (!en_q[i]) begin
                ct_d[i]   = '0;
                pcnt_d[i] = '0;
            end else if (tick[i]) begin
                pcnt_d[i] = '0;
                if (fire[i]) begin
                    ct_d[i] = '0;
                    if (!mode_q[i]) en_d[i] = 1'b0;
                end else begin
                    ct_d[i] = ct_q[i] + CT_ONE;
                end
            end else begin
                pcnt_d[i] = pcnt_q[i] + PCNT_ONE;
            end

            if (ctrlWr[i]) begin
                en_d[i]   = data_i[0];
                ie_d[i]   = data_i[1];
                mode_d[i] = data_i[3];
                if (data_i[0]) begin
                    ct_d[i]   = '0;
                    pcnt_d[i] = '0;
                end
            end
            if (ctWr[i]) begin
                ct_d[i]   = data_i[CNT_W-1:0];
                pcnt_d[i] = '0;
            end
            if (valueWr[i]) value_d[i] = data_i[CNT_W-1:0];
            if (prescWr[i]) presc_d[i] = data_i[PRESC_W-1:0];

            if ((ctrlWr[i] && data_i[2]) || (statusWr && data_i[i])) pend_d[i] = 1'b0;
            if (fire[i]) pend_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q   <= '0;
            ie_q   <= '0;
            pend_q <= '0;
            mode_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ct_q[i]    <= '0;
                value_q[i] <= '0;
                presc_q[i] <= '0;
                pcnt_q[i]  <= '0;
            end
        end else begin
            en_q    <= en_d;
            ie_q    <= ie_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            ct_q    <= ct_d;
            value_q <= value_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end

    // Reads are zero-extended; unmapped channels and offsets return 0.
    always_comb begin
        rdata = '0;
        if (addr_i[7]) begin
            if (addr_i[6:0] == 7'h0) rdata[NUM_CH-1:0] = pend_q;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (addr_i[6:4] == 3'(i)) begin
                    case (addr_i[3:0])
                        4'h0:    rdata[3:0]         = {mode_q[i], pend_q[i], ie_q[i], en_q[i]};
                        4'h4:    rdata[CNT_W-1:0]   = ct_q[i];
                        4'h8:    rdata[CNT_W-1:0]   = value_q[i];
                        4'hC:    rdata[PRESC_W-1:0] = presc_q[i];
                        default: ;
                    endcase
                end
            end
        end
    end

    assign data_o    = rst ? rdata : 32'h0;
    assign int_vec_o = ie_q & pend_q;
    assign int_sig_o = |int_vec_o;

endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
- Parametrised multi-channel successor to the single-channel peripheral timer. It sits on the same simple peripheral bus: 32-bit data/address, single-cycle write strobe, combinational read.
- Provides NUM_CH independent channels. Each channel has a prescaler, a one-shot or periodic (auto-reload) mode, a write-1-to-clear pending flag and an interrupt enable.
- Per-channel interrupt lines are ORed into one interrupt output for the core's interrupt controller.

Parameters:
- NUM_CH, 4, number of channels (1..8).
- CNT_W, 32, counter/compare width (8..32); reads are zero-extended to 32 bits.
- PRESC_W, 16, prescaler register width (1..32).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk.
- data_i  input  32  write data.
- addr_i  input  32  register address; only addr_i[7:0] decoded.
- we_i  input  1  write strobe; one write per cycle at high.
- data_o  output  32  read data; combinational from addr_i.
- int_vec_o  output  NUM_CH  per-channel interrupt, IE & PEND.
- int_sig_o  output  1  OR of int_vec_o.

Behaviour:
- Reset (rst==0 at posedge): all CTRL, CT, VALUE, PRESC, prescaler counters = 0. data_o = 0 while rst==0. int_vec_o = 0, int_sig_o = 0.
- Address map:
  - addr_i[7]=0 selects the channel registers. Channel = addr_i[6:4]; offset addr_i[3:0]: 0x0 CTRL, 0x4 CT, 0x8 VALUE, 0xC PRESC.
  - addr_i[7]=1: 0x80 STATUS. Read returns the PEND bits of all channels in [NUM_CH-1:0]. A write of 1 to bit n clears PEND of channel n.
  - Channel index >= NUM_CH, or an undefined offset: reads 0, writes ignored.
- CTRL bits: [0] EN, [1] IE, [2] PEND (read; write 1 clears), [3] MODE (0 one-shot, 1 periodic). Bits [31:4] are reserved: they read 0 and writes to them are ignored.
- Prescaler:
  - While EN=1, pcnt increments each cycle.
  - When pcnt == PRESC, a tick is generated and pcnt returns to 0. PRESC=0 gives a tick every cycle.
- Counter, on a tick while EN=1:
  - If CT >= VALUE: CT<=0, PEND<=1. If MODE=0, EN<=0.
  - Otherwise CT<=CT+1.
  - CT never wraps past VALUE. VALUE=0 gives an event on every tick.
- EN=0: CT and pcnt are held at 0 from the next cycle. Clearing EN mid-count discards the partial count.
- Latency with PRESC=0: after the write that sets EN, CT counts 0..VALUE. PEND rises VALUE+1 cycles after the first counting cycle, i.e. the period is VALUE+1 ticks.
- Write to CT: loads CT with data_i[CNT_W-1:0] and resets pcnt to 0. It overrides the counter update in that cycle. The load takes effect even if EN=0, but EN=0 zeroes CT on the next cycle.
- Write to VALUE or PRESC: takes effect from the next cycle. CT is not reset. If the new VALUE <= CT, an event fires on the next tick.
- Simultaneous events in the same cycle:
  - Hardware PEND set and a software clear of the same bit: the set wins, so PEND=1.
  - A software CTRL write and a hardware one-shot EN clear: the software EN value wins.
  - A CTRL write that sets EN=1 also resets pcnt and CT to 0.
- Interrupt timing: int_vec_o[n] is combinational from registered IE/PEND. It is high the cycle after the PEND set and stays high until cleared or IE=0.
- Channels are fully independent; no state is shared apart from the STATUS view.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random bus activity -> every register reads 0, int_sig_o=0, data_o=0 during reset.
- One-shot: ch0 VALUE=5, PRESC=0, CTRL=0x3 -> CT reads 0..5. PEND=1 and int_vec_o[0]=1 seven cycles after the CTRL write. EN reads 0 and CT stays 0 afterwards.
- Periodic + prescaler: ch2 VALUE=3, PRESC=2, CTRL=0xB -> PEND every 12 cycles. Write STATUS=0x4 between events -> PEND clears and sets again 12 cycles after the previous event.
- Simultaneous: write a CTRL clear (0xF) to ch1 in the exact cycle its event fires -> PEND remains 1 and int_sig_o stays high.
- Multi-channel: ch0 VALUE=2 and ch3 VALUE=4, both one-shot with IE -> STATUS reads 0x1, then 0x9. int_sig_o stays high until both are cleared. Writes to ch5 (NUM_CH=4) read back 0.
- Reprogram: ch1 periodic with VALUE=100; at CT=50 write VALUE=10 -> an event fires on the next tick and the count restarts at 0 with period 11.
